lcd_text_controller: RTL and testbench
======================================

Name: lcd_text_controller

Overview:
- Parametrised successor to the fixed-sequence LCD control unit.
- Drives an HD44780-compatible character LCD over the 4-bit interface (RS/RW/EN/D[3:0]).
- Performs the power-on init sequence, then accepts characters and clear requests from upstream logic via a valid/ready handshake.
- Tracks the cursor with line wrap and newline handling across a configurable COLS x ROWS panel. Sits between application logic and the board LCD pins.

Parameters:
- COLS, 16, characters per row (1..40)
- ROWS, 2, display rows (1 or 2); row base addresses are 0x00 and 0x40
- T_POWERON, 750000, cycles of power-on wait before first nibble (15 ms at 50 MHz)
- T_INIT1, 205000, wait after first 0x3 init nibble (4.1 ms)
- T_INIT2, 5000, wait after second 0x3 init nibble (100 us)
- T_SETUP, 2, cycles D/RS stable before EN rises
- T_EN_HIGH, 12, cycles EN held high per nibble
- T_NIB_GAP, 50, cycles between low-EN and next nibble (1 us)
- T_CMD, 2000, wait after a normal byte (40 us)
- T_CLEAR, 82000, wait after clear command 0x01 (1.64 ms)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- char_data  in  8  ASCII character to write
- char_valid  in  1  char_data valid
- char_ready  out  1  controller accepts char_data this cycle
- clear_req  in  1  single-cycle request: clear display, cursor home
- init_done  out  1  high once init sequence complete
- cur_col  out  $clog2(COLS)  current cursor column
- cur_row  out  1  current cursor row
- LCD_RS  out  1  register select (0 = command, 1 = data)
- LCD_RW  out  1  read/write; tied 0 (write only)
- LCD_EN  out  1  enable strobe
- LCD_SF_D  out  4  data nibble

Behaviour:
- Reset (reset=0, asynchronous): LCD_RS=0, LCD_RW=0, LCD_EN=0, LCD_SF_D=0, char_ready=0, init_done=0, cur_col=0, cur_row=0. FSM returns to PWR_WAIT. Assertion mid-strobe drops EN immediately, and init restarts from scratch.
- States and transitions:
  - PWR_WAIT (T_POWERON) -> INIT_NIB
  - INIT_NIB sends single nibbles 0x3, 0x3, 0x3, 0x2 with RS=0, each followed by T_INIT1, T_INIT2, T_CMD, T_CMD respectively -> CFG
  - CFG sends bytes 0x28, 0x06, 0x0C, 0x01, each followed by T_CMD, except 0x01, which is followed by T_CLEAR -> IDLE, with init_done=1
  - IDLE: char_ready=1. On clear_req go to the clear sequence; on a char_valid&&char_ready handshake go to WRITE.
  - WRITE: sends the data byte with RS=1, then T_CMD -> ADV
  - ADV: advances the cursor and issues an address command if required -> IDLE
- Single-nibble strobe: drive LCD_SF_D/RS; after T_SETUP cycles EN=1 for T_EN_HIGH cycles; EN=0; then T_NIB_GAP cycles.
- Byte strobe: high nibble, then low nibble, then the post-byte wait.
- Timing counter is sized for the largest parameter. Every wait lasts exactly the parameter count in cycles (±0).
- char_ready is 0 in every state except IDLE. char_data is captured on the handshake cycle, and only one char is accepted per IDLE visit.
- clear_req and char_valid in the same IDLE cycle: clear wins, char_ready forced 0 that cycle, and the char stays pending.
- A clear_req outside IDLE (during init or a write) is latched and served at the next IDLE.
- Clear sequence: byte 0x01 (RS=0), T_CLEAR wait, cur_col=cur_row=0.
- char_data 0x0A (newline): nothing is written to the LCD. cur_col=0, cur_row=(cur_row+1) mod ROWS, then set-address command 0x80|base(row), then T_CMD.
- Printable write: cur_col increments. When it reaches COLS: cur_col=0, cur_row=(cur_row+1) mod ROWS, and 0x80|base(cur_row) is issued. With ROWS=1 this wraps to 0x80.
- LCD_RW is constant 0 in all states.

Optional Feature:
- Macro: LCD_CURSOR_BLINK_EN.
- Defined: CFG display-control byte is 0x0F (display on, cursor on, blink on).
- Undefined: 0x0C (display on, cursor off, blink off).
- No other behaviour differs.

Test Plan:
- Bench parameters: T_POWERON=20, T_INIT1=10, T_INIT2=5, T_CMD=4, T_CLEAR=8, T_SETUP=2, T_EN_HIGH=3, T_NIB_GAP=2, COLS=4, ROWS=2.
- Reset release -> EN pulses carry nibbles 3,3,3,2, then 2,8,0,6,0,C,0,1, all with RS=0; init_done rises after the final T_CLEAR; each EN high lasts exactly 3 cycles.
- After init, char 0x41 handshake -> char_ready drops next cycle; nibbles 4,1 sent with RS=1; cur_col=1; char_ready returns after T_CMD plus ADV.
- Write 4 chars -> after the 4th, command nibbles 0xC,0x0 (0xC0) are sent with RS=0; cur_row=1, cur_col=0. Another 4 chars -> 0x80, cur_row=0.
- char 0x0A at col 2, row 0 -> no RS=1 strobe; command 0xC0 issued; cur_col=0, cur_row=1.
- clear_req and char_valid asserted together in IDLE -> 0x01 sent first, then the pending char at col 0; with LCD_CURSOR_BLINK_EN defined, the init display byte is 0x0F.
- reset pulsed low during an EN-high phase of a data write -> EN=0 and outputs at reset values in the same cycle; the full init sequence restarts; LCD_RW stays 0 throughout.

Source files
------------

// File: rtl/lcd_text_controller.sv
// Purpose : HD44780 4-bit character LCD driver: power-on init, then text/clear with cursor tracking.
// Latency : each nibble = T_SETUP + T_EN_HIGH + T_NIB_GAP cycles, then post-byte/nibble wait.
// Backpr. : char_ready high only in IDLE (and not while a clear is requested or pending).
//
// Ports: clk, reset (async active-low); char_data/char_valid/char_ready upstream handshake;
//        clear_req single-cycle clear request; init_done; cur_col/cur_row cursor position;
//        LCD_RS/LCD_RW/LCD_EN/LCD_SF_D board LCD pins (LCD_RW tied low).
// Build option: define LCD_CURSOR_BLINK_EN to enable cursor + blink (display control 0x0F
//               instead of 0x0C).
module lcd_text_controller #(
    parameter int COLS      = 16,
    parameter int ROWS      = 2,
    parameter int T_POWERON = 750000,
    parameter int T_INIT1   = 205000,
    parameter int T_INIT2   = 5000,
    parameter int T_SETUP   = 2,
    parameter int T_EN_HIGH = 12,
    parameter int T_NIB_GAP = 50,
    parameter int T_CMD     = 2000,
    parameter int T_CLEAR   = 82000
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [7:0]                                char_data,
    input  logic                                      char_valid,
    output logic                                      char_ready,
    input  logic                                      clear_req,
    output logic                                      init_done,
    output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0] cur_col,
    output logic                                      cur_row,
    output logic                                      LCD_RS,
    output logic                                      LCD_RW,
    output logic                                      LCD_EN,
    output logic [3:0]                                LCD_SF_D
);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int TMAX = max2(max2(max2(T_POWERON, T_INIT1), max2(T_INIT2, T_SETUP)),
                               max2(max2(T_EN_HIGH, T_NIB_GAP), max2(T_CMD, T_CLEAR)));
    localparam int CNTW = $clog2(TMAX + 1);

    // Counter reload values are N-1 so that every phase lasts exactly N cycles.
    localparam logic [CNTW-1:0] C_POWERON = CNTW'(T_POWERON - 1);
    localparam logic [CNTW-1:0] C_INIT1   = CNTW'(T_INIT1 - 1);
    localparam logic [CNTW-1:0] C_INIT2   = CNTW'(T_INIT2 - 1);
    localparam logic [CNTW-1:0] C_SETUP   = CNTW'(T_SETUP - 1);
    localparam logic [CNTW-1:0] C_EN      = CNTW'(T_EN_HIGH - 1);
    localparam logic [CNTW-1:0] C_GAP     = CNTW'(T_NIB_GAP - 1);
    localparam logic [CNTW-1:0] C_CMD     = CNTW'(T_CMD - 1);
    localparam logic [CNTW-1:0] C_CLEAR   = CNTW'(T_CLEAR - 1);

`ifdef LCD_CURSOR_BLINK_EN
    localparam logic [7:0] DISP_CTRL = 8'h0F;
`else
    localparam logic [7:0] DISP_CTRL = 8'h0C;
`endif

    typedef enum logic [2:0] {PWR_WAIT, INIT_NIB, CFG, IDLE, WRITE, ADV, ADDR, CLEAR} state_t;
    typedef enum logic [1:0] {PH_SETUP, PH_EN, PH_GAP, PH_WAIT} phase_t;

    state_t          state;
    phase_t          ph;
    logic [CNTW-1:0] cnt;
    logic [1:0]      idx;
    logic [7:0]      tx_dat;
    logic            tx_single;  // one nibble only (init wake-up nibbles)
    logic            tx_lo;      // low nibble of a byte is in flight
    logic [CNTW-1:0] tx_wait;
    logic            clr_pend;
    logic            next_row;
    logic            col_last;

    assign LCD_RW     = 1'b0;
    assign char_ready = (state == IDLE) && !clear_req && !clr_pend;
    assign next_row   = (ROWS > 1) ? ~cur_row : 1'b0;
    assign col_last   = (cur_col == CW'(COLS - 1));

    function automatic logic [7:0] addr_cmd(input logic row);
        return row ? 8'hC0 : 8'h80;
    endfunction

    function automatic logic [7:0] init_nib(input logic [1:0] i);
        return (i == 2'd3) ? 8'h02 : 8'h03;
    endfunction

    function automatic logic [CNTW-1:0] init_wait(input logic [1:0] i);
        case (i)
            2'd0:    return C_INIT1;
            2'd1:    return C_INIT2;
            default: return C_CMD;
        endcase
    endfunction

    function automatic logic [7:0] cfg_byte(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h28;
            2'd1:    return 8'h06;
            2'd2:    return DISP_CTRL;
            default: return 8'h01;
        endcase
    endfunction

    function automatic logic [CNTW-1:0] cfg_wait(input logic [1:0] i);
        return (i == 2'd3) ? C_CLEAR : C_CMD;
    endfunction

    // Load a new transfer; D/RS are presented now, EN rises after the setup phase.
    task automatic start_tx(input logic [7:0] b, input logic rs, input logic single,
                            input logic [CNTW-1:0] w);
        tx_dat    <= b;
        tx_single <= single;
        tx_lo     <= 1'b0;
        tx_wait   <= w;
        LCD_RS    <= rs;
        LCD_SF_D  <= single ? b[3:0] : b[7:4];
        ph        <= PH_SETUP;
        cnt       <= C_SETUP;
    endtask

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= PWR_WAIT;
            ph        <= PH_SETUP;
            cnt       <= C_POWERON;
            idx       <= 2'd0;
            tx_dat    <= 8'h00;
            tx_single <= 1'b0;
            tx_lo     <= 1'b0;
            tx_wait   <= '0;
            clr_pend  <= 1'b0;
            init_done <= 1'b0;
            cur_col   <= '0;
            cur_row   <= 1'b0;
            LCD_RS    <= 1'b0;
            LCD_EN    <= 1'b0;
            LCD_SF_D  <= 4'h0;
        end else begin
            if (clear_req && state != IDLE)
                clr_pend <= 1'b1;
            case (state)
                PWR_WAIT: begin
                    if (cnt == '0) begin
                        state <= INIT_NIB;
                        idx   <= 2'd0;
                        start_tx(init_nib(2'd0), 1'b0, 1'b1, init_wait(2'd0));
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                IDLE: begin
                    if (clear_req || clr_pend) begin
                        clr_pend <= 1'b0;
                        state    <= CLEAR;
                        start_tx(8'h01, 1'b0, 1'b0, C_CLEAR);
                    end else if (char_valid) begin
                        if (char_data == 8'h0A) begin
                            // Newline writes nothing; it only moves the cursor.
                            cur_col <= '0;
                            cur_row <= next_row;
                            state   <= ADDR;
                            start_tx(addr_cmd(next_row), 1'b0, 1'b0, C_CMD);
                        end else begin
                            state <= WRITE;
                            start_tx(char_data, 1'b1, 1'b0, C_CMD);
                        end
                    end
                end
                ADV: begin
                    if (col_last) begin
                        cur_col <= '0;
                        cur_row <= next_row;
                        state   <= ADDR;
                        start_tx(addr_cmd(next_row), 1'b0, 1'b0, C_CMD);
                    end else begin
                        cur_col <= cur_col + CW'(1);
                        state   <= IDLE;
                    end
                end
                default: begin
                    // Transfer engine shared by INIT_NIB, CFG, WRITE, ADDR and CLEAR.
                    case (ph)
                        PH_SETUP: begin
                            if (cnt == '0) begin
                                LCD_EN <= 1'b1;
                                ph     <= PH_EN;
                                cnt    <= C_EN;
                            end else cnt <= cnt - 1'b1;
                        end
                        PH_EN: begin
                            if (cnt == '0) begin
                                LCD_EN <= 1'b0;
                                ph     <= PH_GAP;
                                cnt    <= C_GAP;
                            end else cnt <= cnt - 1'b1;
                        end
                        PH_GAP: begin
                            if (cnt == '0) begin
                                if (!tx_single && !tx_lo) begin
                                    tx_lo    <= 1'b1;
                                    LCD_SF_D <= tx_dat[3:0];
                                    ph       <= PH_SETUP;
                                    cnt      <= C_SETUP;
                                end else begin
                                    ph  <= PH_WAIT;
                                    cnt <= tx_wait;
                                end
                            end else cnt <= cnt - 1'b1;
                        end
                        PH_WAIT: begin
                            if (cnt != '0) begin
                                cnt <= cnt - 1'b1;
                            end else begin
                                case (state)
                                    INIT_NIB: begin
                                        if (idx == 2'd3) begin
                                            state <= CFG;
                                            idx   <= 2'd0;
                                            start_tx(cfg_byte(2'd0), 1'b0, 1'b0, cfg_wait(2'd0));
                                        end else begin
                                            idx <= idx + 2'd1;
                                            start_tx(init_nib(idx + 2'd1), 1'b0, 1'b1,
                                                     init_wait(idx + 2'd1));
                                        end
                                    end
                                    CFG: begin
                                        if (idx == 2'd3) begin
                                            state     <= IDLE;
                                            init_done <= 1'b1;
                                        end else begin
                                            idx <= idx + 2'd1;
                                            start_tx(cfg_byte(idx + 2'd1), 1'b0, 1'b0,
                                                     cfg_wait(idx + 2'd1));
                                        end
                                    end
                                    WRITE: state <= ADV;
                                    ADDR:  state <= IDLE;
                                    default: begin
                                        cur_col <= '0;
                                        cur_row <= 1'b0;
                                        state   <= IDLE;
                                    end
                                endcase
                            end
                        end
                        default: ph <= PH_SETUP;
                    endcase
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_text_controller.sv
module tb_lcd_text_controller;
    localparam int COLS = 4;
    localparam int ROWS = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] char_data = 8'h00;
    logic       char_valid = 1'b0;
    logic       char_ready;
    logic       clear_req = 1'b0;
    logic       init_done;
    logic [1:0] cur_col;
    logic       cur_row;
    logic       LCD_RS, LCD_RW, LCD_EN;
    logic [3:0] LCD_SF_D;

    always #5 clk = ~clk;

    lcd_text_controller #(
        .COLS(COLS), .ROWS(ROWS), .T_POWERON(20), .T_INIT1(10), .T_INIT2(5),
        .T_SETUP(2), .T_EN_HIGH(3), .T_NIB_GAP(2), .T_CMD(4), .T_CLEAR(8)
    ) dut (
        .clk(clk), .reset(reset), .char_data(char_data), .char_valid(char_valid),
        .char_ready(char_ready), .clear_req(clear_req), .init_done(init_done),
        .cur_col(cur_col), .cur_row(cur_row), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
        .LCD_EN(LCD_EN), .LCD_SF_D(LCD_SF_D)
    );

`ifdef LCD_CURSOR_BLINK_EN
    localparam logic [7:0] DISP_BYTE = 8'h0F;
`else
    localparam logic [7:0] DISP_BYTE = 8'h0C;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: expected LCD strobes {rs, nibble} and expected cursor at each IDLE return.
    logic [4:0] exp_q[$];
    logic [2:0] cur_q[$];
    int mcol, mrow;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_nib(input logic rs, input logic [3:0] n);
        exp_q.push_back({rs, n});
    endtask

    task automatic push_byte(input logic rs, input logic [7:0] b);
        push_nib(rs, b[7:4]);
        push_nib(rs, b[3:0]);
    endtask

    task automatic model_init();
        exp_q.delete();
        cur_q.delete();
        push_nib(1'b0, 4'h3); push_nib(1'b0, 4'h3); push_nib(1'b0, 4'h3); push_nib(1'b0, 4'h2);
        push_byte(1'b0, 8'h28); push_byte(1'b0, 8'h06);
        push_byte(1'b0, DISP_BYTE); push_byte(1'b0, 8'h01);
        mcol = 0;
        mrow = 0;
        cur_q.push_back(3'd0);
    endtask

    task automatic model_char(input logic [7:0] c);
        if (c == 8'h0A) begin
            mrow = (mrow + 1) % ROWS;
            mcol = 0;
            push_byte(1'b0, (mrow != 0) ? 8'hC0 : 8'h80);
        end else begin
            push_byte(1'b1, c);
            mcol++;
            if (mcol == COLS) begin
                mcol = 0;
                mrow = (mrow + 1) % ROWS;
                push_byte(1'b0, (mrow != 0) ? 8'hC0 : 8'h80);
            end
        end
        cur_q.push_back(3'(mrow * 4 + mcol));
    endtask

    task automatic model_clear();
        push_byte(1'b0, 8'h01);
        mcol = 0;
        mrow = 0;
        cur_q.push_back(3'd0);
    endtask

    // Compare process: bus decode and cursor checks, sampled on the falling edge.
    int   cyc, en_len, strobes;
    logic prev_en, prev_rdy, prev_init;
    logic [3:0] en_nib;
    logic [4:0] e;
    logic [2:0] ec;

    always @(negedge clk) begin
        if (!reset) begin
            cyc = 0; en_len = 0; strobes = 0;
            prev_en = 1'b0; prev_rdy = 1'b0; prev_init = 1'b0;
        end else begin
            cyc++;
            check("lcd_rw", LCD_RW, 0);
            if (LCD_EN && !prev_en) begin
                if (strobes == 0) check("first_en_cycle", cyc, 22);
                if (strobes < 12) check("init_done_during_init", init_done, 0);
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL strobe_unexpected: got rs=%0d nib=0x%0h with none pending",
                             LCD_RS, LCD_SF_D);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_rs", LCD_RS, e[4]);
                    check("strobe_nib", LCD_SF_D, e[3:0]);
                end
                strobes++;
                en_len = 1;
                en_nib = LCD_SF_D;
            end else if (LCD_EN) begin
                en_len++;
            end
            if (!LCD_EN && prev_en) begin
                check("en_high_len", en_len, 3);
                check("nib_stable", LCD_SF_D, en_nib);
            end
            if (init_done && !prev_init) check("init_done_cycle", cyc, 147);
            if (char_ready && !prev_rdy) begin
                check("ready_init_done", init_done, 1);
                if (cur_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL cursor_unexpected_idle: got %0d/%0d", cur_row, cur_col);
                end else begin
                    ec = cur_q.pop_front();
                    check("cursor", {cur_row, cur_col}, ec);
                end
            end
            prev_en = LCD_EN; prev_rdy = char_ready; prev_init = init_done;
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (char_ready) return;
        end
        n_tests++; n_fail++;
        $display("FAIL wait_ready: got char_ready=0 expected 1 within 3000 cycles");
    endtask

    task automatic send_char(input logic [7:0] c, input bit timing);
        int n;
        wait_ready();
        #1;
        char_data = c; char_valid = 1'b1;
        model_char(c);
        @(posedge clk); #1;
        char_valid = 1'b0;
        if (timing) begin
            @(negedge clk);
            check("ready_drop", char_ready, 0);
            n = 1;
            while (!char_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("ready_return_cycles", n, 20);
        end
    endtask

    task automatic send_clear();
        wait_ready();
        #1;
        clear_req = 1'b1;
        model_clear();
        @(posedge clk); #1;
        clear_req = 1'b0;
    endtask

    task automatic clear_and_char(input logic [7:0] c);
        wait_ready();
        #1;
        clear_req = 1'b1; char_valid = 1'b1; char_data = c;
        #1;
        check("ready_forced_low", char_ready, 0);
        model_clear();
        model_char(c);
        @(posedge clk); #1;
        clear_req = 1'b0;
        wait_ready();
        @(posedge clk); #1;
        char_valid = 1'b0;
    endtask

    task automatic latched_clear(input logic [7:0] c);
        send_char(c, 1'b0);
        @(negedge clk); #1;
        clear_req = 1'b1;
        void'(cur_q.pop_back());  // pending clear suppresses the char's own IDLE return
        model_clear();
        @(posedge clk); #1;
        clear_req = 1'b0;
    endtask

    function automatic logic [7:0] rand_char();
        if ($urandom_range(0, 5) == 0) return 8'h0A;
        return 8'($urandom_range(32, 126));
    endfunction

    initial begin
        model_init();
        repeat (3) @(negedge clk);
        #1;
        check("rst_en", LCD_EN, 0);
        check("rst_ready", char_ready, 0);
        check("rst_init_done", init_done, 0);
        check("rst_d", LCD_SF_D, 0);
        reset = 1'b1;

        // Directed: first char, wrap to row 1, wrap back to row 0, newline at col 2.
        send_char(8'h41, 1'b1);
        for (int i = 0; i < 3; i++) send_char(8'h42 + 8'(i), 1'b0);
        wait_ready();
        check("wrap_row1", {cur_row, cur_col}, 3'b100);
        for (int i = 0; i < 4; i++) send_char(8'h61 + 8'(i), 1'b0);
        wait_ready();
        check("wrap_row0", {cur_row, cur_col}, 3'b000);
        send_char(8'h31, 1'b0);
        send_char(8'h32, 1'b0);
        send_char(8'h0A, 1'b0);
        wait_ready();
        check("newline_pos", {cur_row, cur_col}, 3'b100);
        clear_and_char(8'h5A);
        wait_ready();
        check("clear_then_char", {cur_row, cur_col}, 3'b001);
        latched_clear(8'h33);

        // Randomized traffic.
        for (int k = 0; k < 120; k++) begin
            case ($urandom_range(0, 9))
                0:       send_clear();
                1:       latched_clear(rand_char());
                2:       clear_and_char(rand_char());
                default: send_char(rand_char(), 1'b0);
            endcase
        end

        // Reset asserted during the EN-high phase of a data write.
        send_char(8'h58, 1'b0);
        begin
            int n = 0;
            while (!(LCD_EN && LCD_RS) && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("found_data_strobe", {31'd0, LCD_EN && LCD_RS}, 1);
        end
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_en", LCD_EN, 0);
        check("mid_rst_rs", LCD_RS, 0);
        check("mid_rst_d", LCD_SF_D, 0);
        check("mid_rst_rw", LCD_RW, 0);
        check("mid_rst_ready", char_ready, 0);
        check("mid_rst_init_done", init_done, 0);
        check("mid_rst_cursor", {cur_row, cur_col}, 0);
        model_init();
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) send_char(rand_char(), 1'b0);
        wait_ready();
        repeat (5) @(negedge clk);
        check("strobes_left", exp_q.size(), 0);
        check("cursor_left", cur_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end
endmodule
